lsu: RTL

Parametrised load/store unit that replaces the zero-latency combinational memory access in the MMU stage with a multi-cycle request/response bus master. It accepts one load or store per operation from the EXU/MMU boundary and produces the byte strobes. For loads it sign- or zero-extends the returned data. Accesses that cross an XLEN-aligned word are split into two bus beats, and the unit stalls the pipeline until the access completes.

---
 rtl/lsu.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Multi-cycle load/store unit: request/response bus master with byte strobes,
// split handling for word-crossing accesses and sign/zero extension of loads.
module lsu #(
  parameter int XLEN = 64,
  parameter int NB   = XLEN / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              exu_valid,
  input  logic              exu_load_en,
  input  logic              exu_store_en,
  input  logic [2:0]        exu_mem_op,
  input  logic [XLEN-1:0]   exu_addr,
  input  logic [XLEN-1:0]   exu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [NB-1:0]     mem_req_wstrb,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);
  localparam int OFFW = $clog2(NB);
  localparam int SW   = OFFW + 2;
  localparam int NB2  = 2 * NB;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [XLEN-1:0]   beat0_q, beat0_d, beat1_q, beat1_d;
  logic              we_q, we_d, err_q, err_d;

  logic [OFFW-1:0]   off;
  logic [SW-1:0]     size, span;
  logic              split, illegal, go, sgn;
  logic [OFFW+2:0]   sh;
  logic [NB2-1:0]    strb_full;
  logic [2*XLEN-1:0] wd_full;
  logic [XLEN-1:0]   ld_sh, word_addr, mask, ld_ext;

  assign go        = exu_valid & (exu_load_en | exu_store_en);
  assign illegal   = (exu_mem_op == 3'b111) | (exu_store_en & exu_mem_op[2]) |
                     ((XLEN == 32) & ((exu_mem_op[1:0] == 2'b11) | (exu_mem_op == 3'b110)));

  assign off       = addr_q[OFFW-1:0];
  assign size      = SW'(1) << op_q[1:0];
  assign span      = SW'(off) + size;
  assign split     = span > SW'(NB);
  assign sh        = {off, 3'b000};
  assign word_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  // Strobes and data are formed over a double word; each beat takes one half.
  assign strb_full = ((NB2'(1) << size) - NB2'(1)) << off;
  assign wd_full   = {wdata_q, wdata_q} << sh;
  assign ld_sh     = XLEN'({beat1_q, beat0_q} >> sh);

  always_comb begin
    mask = '1;
    sgn  = ld_sh[XLEN-1];
    case (op_q[1:0])
      2'd0: begin mask = ~({XLEN{1'b1}} << 8);  sgn = ld_sh[7];  end
      2'd1: begin mask = ~({XLEN{1'b1}} << 16); sgn = ld_sh[15]; end
      2'd2: begin mask = ~({XLEN{1'b1}} << 32); sgn = ld_sh[31]; end
      default: ;
    endcase
    ld_ext = (ld_sh & mask) | ((sgn & ~op_q[2]) ? ~mask : '0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    lsu_stall     = 1'b0;
    lsu_done      = 1'b0;
    lsu_rdata     = '0;
    lsu_err       = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wstrb = '0;
    mem_req_wdata = '0;
    case (state_q)
      IDLE: begin
        if (go) begin
          lsu_stall = 1'b1;
          op_d      = exu_mem_op;
          addr_d    = exu_addr;
          wdata_d   = exu_wdata;
          we_d      = exu_store_en;
          err_d     = illegal;
          beat0_d   = '0;
          beat1_d   = '0;
          state_d   = illegal ? DONE : REQ0;
        end
      end
      REQ0: begin
        lsu_stall     = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = word_addr;
        mem_req_wstrb = strb_full[NB-1:0];
        mem_req_wdata = we_q ? wd_full[XLEN-1:0] : '0;
        if (mem_req_ready) state_d = WAIT0;
      end
      WAIT0: begin
        lsu_stall = 1'b1;
        if (mem_resp_valid) begin
          beat0_d = mem_resp_rdata;
          state_d = split ? REQ1 : DONE;
        end
      end
      REQ1: begin
        lsu_stall     = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = word_addr + XLEN'(NB);
        mem_req_wstrb = strb_full[NB2-1:NB];
        mem_req_wdata = we_q ? wd_full[2*XLEN-1:XLEN] : '0;
        if (mem_req_ready) state_d = WAIT1;
      end
      WAIT1: begin
        lsu_stall = 1'b1;
        if (mem_resp_valid) begin
          beat1_d = mem_resp_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        lsu_done  = 1'b1;
        lsu_err   = err_q;
        lsu_rdata = (we_q | err_q) ? '0 : ld_ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      beat0_q <= '0;
      beat1_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
    end
  end
endmodule
